// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: default sizes,
// stage indices and the controller state encoding.
package pipeline_ctrl_pkg;

  localparam int DEF_STAGES     = 5;
  localparam int DEF_ADDR_WIDTH = 32;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [0:0] {
    CTRL_IDLE  = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Saturating count of consecutive stalled cycles; raises stall_timeout while
// the count sits at all-ones.
module pipeline_ctrl_stall_watchdog #(
  parameter int WDT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  output logic stall_timeout
);

  localparam logic [WDT_WIDTH-1:0] SAT = '1;

  logic [WDT_WIDTH-1:0] count;
  logic [WDT_WIDTH-1:0] count_nxt;

  always_comb begin
    count_nxt = '0;
    if (count_en) begin
      count_nxt = (count == SAT) ? SAT : count + 1'b1;
    end
  end

  // Flag is registered from the next count so it lines up with the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count         <= '0;
      stall_timeout <= 1'b0;
    end else begin
      count         <= count_nxt;
      stall_timeout <= (count_nxt == SAT);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: per-stage stall prefix-OR, exception/branch
// redirect with a timed flush window, and a stall watchdog.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   CTRL_IDLE  | normal flow; stalls follow requests, redirects accepted
//   CTRL_FLUSH | flush asserted; only exceptions restart the window
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STAGES       = DEF_STAGES,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int FLUSH_CYCLES = 2,
  parameter int WDT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STAGES-1:0]     stall_req,
  input  logic                  exc_req,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  input  logic                  branch_req,
  input  logic [ADDR_WIDTH-1:0] branch_pc,
  output logic [STAGES-1:0]     stall,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  stall_timeout
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_e           state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic                  load;
  logic [STAGES-1:0]     prefix_or;

  // A request at stage k holds k and every earlier stage.
  for (genvar i = 0; i < STAGES; i++) begin : g_stall
    assign prefix_or[i] = |stall_req[STAGES-1:i];
  end

  assign stall = (!rst || state == CTRL_FLUSH) ? '0 : prefix_or;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = redirect_pc;
    load      = 1'b0;
    case (state)
      CTRL_IDLE: begin
        if (exc_req) begin
          load   = 1'b1;
          pc_nxt = exc_pc;
        end else if (branch_req) begin
          load   = 1'b1;
          pc_nxt = branch_pc;
        end
      end
      CTRL_FLUSH: begin
        if (exc_req) begin
          load   = 1'b1;
          pc_nxt = exc_pc;
        end else if (cnt == '0) begin
          state_nxt = CTRL_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = CTRL_IDLE;
    endcase
    if (load) begin
      state_nxt = CTRL_FLUSH;
      cnt_nxt   = CNT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= CTRL_IDLE;
      cnt            <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      flush          <= (state_nxt == CTRL_FLUSH);
      redirect_valid <= load;
      redirect_pc    <= pc_nxt;
    end
  end

  pipeline_ctrl_stall_watchdog #(
    .WDT_WIDTH(WDT_WIDTH)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .count_en     ((state == CTRL_IDLE) && (|stall_req)),
    .stall_timeout(stall_timeout)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int ST   = 5;
  localparam int AW   = 32;
  localparam int FC   = 2;
  localparam int WW   = 8;
  localparam int WMAX = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [ST-1:0] stall_req;
  logic          exc_req, branch_req;
  logic [AW-1:0] exc_pc, branch_pc;
  logic [ST-1:0] stall;
  logic          flush, redirect_valid, stall_timeout;
  logic [AW-1:0] redirect_pc;

  pipeline_ctrl #(
    .STAGES(ST), .ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .WDT_WIDTH(WW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req     (stall_req),
    .exc_req       (exc_req),
    .exc_pc        (exc_pc),
    .branch_req    (branch_req),
    .branch_pc     (branch_pc),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: remaining flush cycles, redirect pulse/pc, stalled-cycle run length
  int          m_left = 0;
  int          m_wdt  = 0;
  logic        m_rv   = 1'b0;
  logic [AW-1:0] m_pc = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ST-1:0] exp_stall();
    if (!rst || m_left > 0) return '0;
    for (int i = ST - 1; i >= 0; i--)
      if (stall_req[i]) return ST'((1 << (i + 1)) - 1);
    return '0;
  endfunction

  task automatic model_reset();
    m_left = 0; m_wdt = 0; m_rv = 1'b0; m_pc = '0;
  endtask

  task automatic model_edge();
    bit in_flush;
    in_flush = (m_left > 0);
    if (exc_req) begin
      m_left = FC; m_rv = 1'b1; m_pc = exc_pc;
    end else if (branch_req && !in_flush) begin
      m_left = FC; m_rv = 1'b1; m_pc = branch_pc;
    end else begin
      m_rv = 1'b0;
      if (m_left > 0) m_left--;
    end
    if (!in_flush && (stall_req != '0)) m_wdt = (m_wdt < WMAX) ? m_wdt + 1 : WMAX;
    else m_wdt = 0;
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic run_cycle();
    #1;
    check("stall", 64'(stall), 64'(exp_stall()));
    check("flush", 64'(flush), 64'(m_left > 0));
    check("redirect_valid", 64'(redirect_valid), 64'(m_rv));
    check("redirect_pc", 64'(redirect_pc), 64'(m_pc));
    check("stall_timeout", 64'(stall_timeout), 64'(m_wdt == WMAX));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    stall_req = '0; exc_req = 1'b0; branch_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    exc_pc = '0; branch_pc = '0;
    stall_req = 5'b10000;
    #2;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_flush", 64'(flush), 64'd0);
    check("reset_rv", 64'(redirect_valid), 64'd0);
    check("reset_pc", 64'(redirect_pc), 64'd0);
    check("reset_timeout", 64'(stall_timeout), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    run_cycle();

    // 1: MEM stall
    stall_req = 5'b01000;
    #1;
    check("t1_stall", 64'(stall), 64'h0f);
    run_cycle();
    idle_inputs();
    run_cycle();

    // 2: exception redirect and flush window
    exc_req = 1'b1; exc_pc = 32'hBFC00380;
    run_cycle();
    exc_req = 1'b0;
    #1;
    check("t2_flush_t1", 64'(flush), 64'd1);
    check("t2_rv_t1", 64'(redirect_valid), 64'd1);
    check("t2_pc_t1", 64'(redirect_pc), 64'hBFC00380);
    run_cycle();
    check("t2_flush_t2", 64'(flush), 64'd1);
    check("t2_rv_t2", 64'(redirect_valid), 64'd0);
    run_cycle();
    check("t2_flush_t3", 64'(flush), 64'd0);
    run_cycle();

    // 3: exception beats branch
    exc_req = 1'b1; exc_pc = 32'hBFC00380;
    branch_req = 1'b1; branch_pc = 32'h00400100;
    run_cycle();
    idle_inputs();
    check("t3_pc", 64'(redirect_pc), 64'hBFC00380);
    repeat (3) run_cycle();

    // 4: branch then exception restarts the window
    branch_req = 1'b1; branch_pc = 32'h00400100;
    run_cycle();
    idle_inputs();
    exc_req = 1'b1; exc_pc = 32'h80000180;
    run_cycle();
    idle_inputs();
    check("t4_rv_t2", 64'(redirect_valid), 64'd1);
    check("t4_pc_t2", 64'(redirect_pc), 64'h80000180);
    run_cycle();
    check("t4_flush_t3", 64'(flush), 64'd1);
    repeat (2) run_cycle();

    // 5: watchdog saturation
    stall_req = 5'b00100;
    repeat (254) run_cycle();
    check("t5_before", 64'(stall_timeout), 64'd0);
    run_cycle();
    check("t5_timeout", 64'(stall_timeout), 64'd1);
    run_cycle();
    stall_req = '0;
    run_cycle();
    check("t5_cleared", 64'(stall_timeout), 64'd0);

    // 6: reset in the middle of a flush
    exc_req = 1'b1; exc_pc = 32'h12345678;
    run_cycle();
    exc_req = 1'b0; stall_req = 5'b00010;
    check("t6_flush_pre", 64'(flush), 64'd1);
    rst = 1'b0;
    #1;
    check("t6_flush_rst", 64'(flush), 64'd0);
    check("t6_rv_rst", 64'(redirect_valid), 64'd0);
    check("t6_stall_rst", 64'(stall), 64'd0);
    check("t6_pc_rst", 64'(redirect_pc), 64'd0);
    model_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) run_cycle();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      exc_req    = ($urandom_range(0, 15) == 0);
      branch_req = ($urandom_range(0, 5) == 0);
      exc_pc     = $urandom;
      branch_pc  = $urandom;
      stall_req  = ($urandom_range(0, 1) == 0) ? '0 : ST'($urandom);
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
